// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one completed functional-unit result per cycle
// (optional fixed branch priority plus round-robin) and registers it onto the CDB.
module cdb_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TAG_W       = 3,
    parameter int DATA_W      = 32,
    parameter int BR_PRIORITY = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]        req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]       req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            cdb_valid,
    output logic [TAG_W-1:0]                cdb_tag,
    output logic [DATA_W-1:0]               cdb_data,
    output logic [$clog2(NUM_REQ)-1:0]      cdb_src,
    output logic [15:0]                     stall_cnt
);

    localparam int SRC_W = $clog2(NUM_REQ);
    // Lowest index that takes part in rotation; requester 0 sits outside it under branch priority.
    localparam int FIRST_ROT = (BR_PRIORITY != 0) ? 1 : 0;
    localparam logic [SRC_W-1:0] PTR_RESET = SRC_W'(FIRST_ROT);

    logic [TAG_W-1:0]  tag_arr  [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign tag_arr[gi]  = req_tag[gi*TAG_W +: TAG_W];
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic [SRC_W-1:0] ptr_reg, ptr_next;
    logic             cdb_valid_reg;
    logic [TAG_W-1:0] cdb_tag_reg;
    logic [DATA_W-1:0] cdb_data_reg;
    logic [SRC_W-1:0] cdb_src_reg;
    logic [15:0]      stall_cnt_reg;

    logic             grant_any;
    logic             rot_grant;
    logic             stall_inc;
    logic [SRC_W-1:0] grant_sel;
    int               win_int;
    int               idx_int;
    int               active_cnt;

    always_comb begin
        req_ready  = '0;
        grant_any  = 1'b0;
        rot_grant  = 1'b0;
        stall_inc  = 1'b0;
        win_int    = 0;
        idx_int    = 0;
        active_cnt = 0;
        ptr_next   = ptr_reg;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_valid[k]) active_cnt = active_cnt + 1;
        end
        if (!rst && !flush) begin
            if (BR_PRIORITY != 0 && req_valid[0]) begin
                grant_any = 1'b1;
                win_int   = 0;
            end else begin
                // Scanning the full ring and skipping index 0 gives the 1..N-1 wrap order.
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx_int = (int'(ptr_reg) + k) % NUM_REQ;
                    if (!grant_any && idx_int >= FIRST_ROT && req_valid[idx_int[SRC_W-1:0]]) begin
                        grant_any = 1'b1;
                        rot_grant = 1'b1;
                        win_int   = idx_int;
                    end
                end
            end
            stall_inc = (active_cnt >= 2);
        end
        grant_sel = win_int[SRC_W-1:0];
        if (grant_any) req_ready[grant_sel] = 1'b1;
        if (rot_grant) ptr_next = (win_int == NUM_REQ - 1) ? PTR_RESET : SRC_W'(win_int + 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg       <= PTR_RESET;
            cdb_valid_reg <= 1'b0;
            cdb_tag_reg   <= '0;
            cdb_data_reg  <= '0;
            cdb_src_reg   <= '0;
            stall_cnt_reg <= '0;
        end else begin
            ptr_reg       <= ptr_next;
            cdb_valid_reg <= grant_any;
            if (grant_any) begin
                cdb_tag_reg  <= tag_arr[grant_sel];
                cdb_data_reg <= data_arr[grant_sel];
                cdb_src_reg  <= grant_sel;
            end
            if (stall_inc && stall_cnt_reg != 16'hFFFF) stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign cdb_valid = cdb_valid_reg;
    assign cdb_tag   = cdb_tag_reg;
    assign cdb_data  = cdb_data_reg;
    assign cdb_src   = cdb_src_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: one instance with branch priority, one fully rotating,
// both driven by the same requester stimulus.
module tb_cdb_arbiter;

    logic          clk;
    logic          rst;
    logic          flush;
    logic [3:0]    req_valid;
    logic [11:0]   req_tag;
    logic [127:0]  req_data;

    logic [3:0]    ready_br, ready_rr;
    logic          cdb_valid_br, cdb_valid_rr;
    logic [2:0]    cdb_tag_br, cdb_tag_rr;
    logic [31:0]   cdb_data_br, cdb_data_rr;
    logic [1:0]    cdb_src_br, cdb_src_rr;
    logic [15:0]   stall_br, stall_rr;

    int checks   = 0;
    int failures = 0;

    cdb_arbiter #(.NUM_REQ(4), .TAG_W(3), .DATA_W(32), .BR_PRIORITY(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
        .req_ready(ready_br), .cdb_valid(cdb_valid_br), .cdb_tag(cdb_tag_br),
        .cdb_data(cdb_data_br), .cdb_src(cdb_src_br), .stall_cnt(stall_br)
    );

    cdb_arbiter #(.NUM_REQ(4), .TAG_W(3), .DATA_W(32), .BR_PRIORITY(0)) dut_rr (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
        .req_ready(ready_rr), .cdb_valid(cdb_valid_rr), .cdb_tag(cdb_tag_rr),
        .cdb_data(cdb_data_rr), .cdb_src(cdb_src_rr), .stall_cnt(stall_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tag i = i, data i = A000_000i for every requester.
    task automatic load_payload;
        req_tag  = {3'd3, 3'd2, 3'd1, 3'd0};
        req_data = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; req_valid = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; req_valid = 4'b1111; load_payload();
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (ready_br !== 4'b0000 || ready_rr !== 4'b0000) begin
                failures++;
                $display("FAIL reset_ready cyc=%0d got br=%b rr=%b exp=0000", c, ready_br, ready_rr);
            end
            @(negedge clk);
        end
        rst = 1'b0; req_valid = 4'b0000;
        #1;
        checks++;
        if (cdb_valid_br !== 1'b0 || cdb_valid_rr !== 1'b0 || stall_br !== 16'd0 || stall_rr !== 16'd0) begin
            failures++;
            $display("FAIL reset_state got valid=%b/%b stall=%0d/%0d exp valid=0 stall=0",
                     cdb_valid_br, cdb_valid_rr, stall_br, stall_rr);
        end
        $display("test_reset done");
    endtask

    task automatic test_rotation;
        do_reset();
        load_payload();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            #1;
            checks++;
            if (ready_rr !== 4'(1 << (k % 4))) begin
                failures++;
                $display("FAIL rot_ready cyc=%0d got=%b exp=%b", k, ready_rr, 4'(1 << (k % 4)));
            end
            @(posedge clk); #1;
            checks++;
            if (cdb_valid_rr !== 1'b1 || cdb_tag_rr !== 3'(k % 4) || cdb_src_rr !== 2'(k % 4)) begin
                failures++;
                $display("FAIL rot_cdb cyc=%0d got v=%b tag=%0d src=%0d exp v=1 tag=%0d src=%0d",
                         k, cdb_valid_rr, cdb_tag_rr, cdb_src_rr, k % 4, k % 4);
            end
            checks++;
            if (stall_rr !== 16'(k + 1)) begin
                failures++;
                $display("FAIL rot_stall cyc=%0d got=%0d exp=%0d", k, stall_rr, k + 1);
            end
            $display("rotation cyc=%0d ready=%b tag=%0d stall=%0d", k, ready_rr, cdb_tag_rr, stall_rr);
        end
        @(negedge clk);
        req_valid = 4'b0000;
    endtask

    task automatic test_br_priority;
        logic [3:0] vin  [5] = '{4'b1110, 4'b1110, 4'b1111, 4'b1110, 4'b1110};
        logic [3:0] rdy  [5] = '{4'b0010, 4'b0100, 4'b0001, 4'b1000, 4'b0010};
        logic [1:0] src  [5] = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd1};
        do_reset();
        load_payload();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_valid = vin[k];
            #1;
            checks++;
            if (ready_br !== rdy[k]) begin
                failures++;
                $display("FAIL br_ready cyc=%0d got=%b exp=%b", k, ready_br, rdy[k]);
            end
            @(posedge clk); #1;
            checks++;
            if (cdb_valid_br !== 1'b1 || cdb_src_br !== src[k] || cdb_tag_br !== 3'(src[k])
                || cdb_data_br !== (32'hA000_0000 | 32'(src[k]))) begin
                failures++;
                $display("FAIL br_cdb cyc=%0d got v=%b src=%0d tag=%0d data=%h exp src=%0d",
                         k, cdb_valid_br, cdb_src_br, cdb_tag_br, cdb_data_br, src[k]);
            end
            checks++;
            if (stall_br !== 16'(k + 1)) begin
                failures++;
                $display("FAIL br_stall cyc=%0d got=%0d exp=%0d", k, stall_br, k + 1);
            end
            $display("br_priority cyc=%0d valid=%b ready=%b src=%0d", k, vin[k], ready_br, cdb_src_br);
        end
    endtask

    task automatic test_data_path;
        // Stall counts carried over from the priority test: br=5.
        @(negedge clk);
        req_valid = 4'b0100;
        req_tag[8:6]    = 3'd5;
        req_data[95:64] = 32'hDEADBEEF;
        #1;
        checks++;
        if (ready_br !== 4'b0100 || ready_rr !== 4'b0100) begin
            failures++;
            $display("FAIL data_ready got br=%b rr=%b exp=0100", ready_br, ready_rr);
        end
        @(posedge clk); #1;
        checks++;
        if (cdb_valid_br !== 1'b1 || cdb_tag_br !== 3'd5 || cdb_data_br !== 32'hDEADBEEF || cdb_src_br !== 2'd2) begin
            failures++;
            $display("FAIL data_cdb got v=%b tag=%0d data=%h src=%0d exp v=1 tag=5 data=deadbeef src=2",
                     cdb_valid_br, cdb_tag_br, cdb_data_br, cdb_src_br);
        end
        checks++;
        if (stall_br !== 16'd5) begin
            failures++;
            $display("FAIL data_stall got=%0d exp=5", stall_br);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checks++;
        if (ready_br !== 4'b0000) begin
            failures++;
            $display("FAIL idle_ready got=%b exp=0000", ready_br);
        end
        @(posedge clk); #1;
        checks++;
        if (cdb_valid_br !== 1'b0) begin
            failures++;
            $display("FAIL idle_valid got=%b exp=0", cdb_valid_br);
        end
        $display("data_path tag=%0d data=%h src=%0d", cdb_tag_br, cdb_data_br, cdb_src_br);
        load_payload();
    endtask

    task automatic test_flush;
        do_reset();
        load_payload();
        // Move both pointers to 2 first.
        @(negedge clk);
        req_valid = 4'b1110;
        @(posedge clk); #1;
        checks++;
        if (cdb_valid_br !== 1'b1 || cdb_src_br !== 2'd1 || cdb_valid_rr !== 1'b1 || cdb_src_rr !== 2'd1) begin
            failures++;
            $display("FAIL flush_pre got src=%0d/%0d exp 1/1", cdb_src_br, cdb_src_rr);
        end
        @(negedge clk);
        req_valid = 4'b1111; flush = 1'b1;
        #1;
        checks++;
        if (ready_br !== 4'b0000 || ready_rr !== 4'b0000) begin
            failures++;
            $display("FAIL flush_ready got br=%b rr=%b exp=0000", ready_br, ready_rr);
        end
        @(posedge clk); #1;
        checks++;
        if (cdb_valid_br !== 1'b0 || cdb_valid_rr !== 1'b0 || stall_br !== 16'd1 || stall_rr !== 16'd1) begin
            failures++;
            $display("FAIL flush_after got valid=%b/%b stall=%0d/%0d exp valid=0 stall=1",
                     cdb_valid_br, cdb_valid_rr, stall_br, stall_rr);
        end
        @(negedge clk);
        flush = 1'b0; req_valid = 4'b1110;
        #1;
        checks++;
        if (ready_br !== 4'b0100 || ready_rr !== 4'b0100) begin
            failures++;
            $display("FAIL flush_resume got br=%b rr=%b exp=0100", ready_br, ready_rr);
        end
        @(posedge clk); #1;
        checks++;
        if (stall_br !== 16'd2 || cdb_src_br !== 2'd2) begin
            failures++;
            $display("FAIL flush_resume_cdb got stall=%0d src=%0d exp stall=2 src=2", stall_br, cdb_src_br);
        end
        $display("flush resume ready=%b stall=%0d", ready_br, stall_br);
    endtask

    task automatic test_reset_mid;
        // Pointers are at 3 after the flush test; reset with flush also high.
        @(negedge clk);
        req_valid = 4'b1110; rst = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (ready_br !== 4'b0000) begin
            failures++;
            $display("FAIL rstmid_ready got=%b exp=0000", ready_br);
        end
        @(posedge clk); #1;
        checks++;
        if (cdb_valid_br !== 1'b0 || cdb_tag_br !== 3'd0 || cdb_data_br !== 32'd0 || cdb_src_br !== 2'd0 || stall_br !== 16'd0) begin
            failures++;
            $display("FAIL rstmid_state got v=%b tag=%0d data=%h src=%0d stall=%0d exp all zero",
                     cdb_valid_br, cdb_tag_br, cdb_data_br, cdb_src_br, stall_br);
        end
        @(negedge clk);
        rst = 1'b0; flush = 1'b0;
        #1;
        checks++;
        if (ready_br !== 4'b0010 || ready_rr !== 4'b0010) begin
            failures++;
            $display("FAIL rstmid_ptr got br=%b rr=%b exp=0010", ready_br, ready_rr);
        end
        @(posedge clk);
        $display("reset_mid ready=%b", ready_br);
    endtask

    task automatic test_saturation;
        do_reset();
        @(negedge clk);
        req_valid = 4'b0011;
        repeat (65534) @(posedge clk);
        #1;
        checks++;
        if (stall_br !== 16'hFFFE || stall_rr !== 16'hFFFE) begin
            failures++;
            $display("FAIL sat_edge got=%h/%h exp=fffe", stall_br, stall_rr);
        end
        @(posedge clk); #1;
        checks++;
        if (stall_br !== 16'hFFFF || stall_rr !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_reach got=%h/%h exp=ffff", stall_br, stall_rr);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (stall_br !== 16'hFFFF || stall_rr !== 16'hFFFF || cdb_src_br !== 2'd0 || cdb_valid_br !== 1'b1) begin
            failures++;
            $display("FAIL sat_hold got=%h/%h src=%0d v=%b exp ffff src=0 v=1",
                     stall_br, stall_rr, cdb_src_br, cdb_valid_br);
        end
        $display("saturation stall=%h/%h", stall_br, stall_rr);
        @(negedge clk);
        req_valid = 4'b0000;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 4'b0000;
        req_tag = '0; req_data = '0;
        test_reset();
        test_rotation();
        test_br_priority();
        test_data_path();
        test_flush();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
